data_bus_arbiter: RTL and testbench
===================================

# data_bus_arbiter

Two-master arbiter sharing the single memory data bus between the CPU core (master 0: instruction fetch, load, store) and a second bus master (master 1: page-table walker / DMA). It grants one master per transaction, steers that master's strobes, address, write data and access width to the memory slave, and returns data and `ready` only to the granted master. A watchdog aborts transactions the slave never completes.

## Interface
Parameters:
- `FIXED_PRIO`, 0: 0 = round-robin on contention; 1 = master 0 always wins.
- `TIMEOUT`, 255: maximum BUSY cycles before abort; 0 disables the watchdog. Counter width is `$clog2(TIMEOUT+1)` (min 1).

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `res`  in  1  asynchronous, active-high reset.
- `m0_read`, `m0_write`  in  1  master 0 strobes, held until `m0_ready`.
- `m0_addr`  in  32  master 0 byte address.
- `m0_dataOut`  in  32  master 0 write data.
- `m0_memType`  in  2  master 0 access width code, passed through unmodified.
- `m0_dataIn`  out  32  read data to master 0.
- `m0_ready`  out  1  transaction complete for master 0.
- `m0_err`  out  1  watchdog abort for master 0, one-cycle pulse.
- `m1_*`  same set and widths for master 1.
- `s_read`, `s_write`  out  1  slave strobes.
- `s_addr`  out  32; `s_dataOut`  out  32; `s_memType`  out  2  slave request fields.
- `s_dataIn`  in  32; `s_ready`  in  1  slave response.
- `grant`  out  2  one-hot owner (bit0 = m0, bit1 = m1), 0 when idle.
- `timeoutFlag`  out  1  sticky: set by any watchdog abort.
- `clearTimeout`  in  1  synchronous clear of `timeoutFlag`.

## Operation
- States: IDLE, BUSY0, BUSY1, DONE.
- IDLE: request of master n = `mn_read | mn_write`. One requester → BUSYn. Both → FIXED_PRIO=1: BUSY0; else the master not equal to `lastGrant`. Neither → stay. `lastGrant` updates on entry to BUSYn.
- BUSYn: `grant` bit n = 1; `s_*` fields combinationally muxed from master n; `s_write = mn_write`, `s_read = mn_read & ~mn_write` (write wins if both asserted). Other master's outputs held at 0.
- BUSYn with `s_ready`=1: `mn_ready`=1 and `mn_dataIn = s_dataIn` in that same cycle; → DONE.
- BUSYn with master dropping both strobes before `s_ready`: abort silently, no `ready`, → IDLE next cycle.
- Watchdog: counter clears on BUSY entry, increments each BUSY cycle without `s_ready`. In the cycle counter == TIMEOUT−1 without `s_ready`: `mn_ready`=1, `mn_err`=1, `mn_dataIn`=0, `timeoutFlag` set, → DONE. `s_ready` in that cycle wins (normal completion, no error).
- DONE: one bubble cycle, all `s_*` strobes 0, `grant`=0, so the completing master can drop its request; → IDLE.
- `timeoutFlag`: set on abort, cleared by `clearTimeout`; set takes precedence when both coincide.
- `mn_dataIn` is 0 whenever master n is not receiving `ready`.

## Timing
- Reset (async): state IDLE, `lastGrant` = 1 (m0 wins first contention), counter 0, `timeoutFlag` 0; all outputs 0.
- Arbitration latency: request seen in IDLE at edge k → strobes on slave from cycle k+1.
- Minimum transaction: IDLE, BUSY (slave ready same cycle), DONE = 3 cycles; back-to-back from one master: one request per 3 cycles.
- Reset asserted mid-transaction: strobes drop immediately (asynchronously); no `ready` delivered.
- Requests arriving in BUSY/DONE wait; no request is lost while held.

## Test plan
- Single read: m0_read, addr 0x100, slave ready after 2 BUSY cycles with 0xDEADBEEF → `m0_ready`=1 with `m0_dataIn`=0xDEADBEEF in the 3rd cycle after IDLE; `grant`=01 during BUSY; `m1_ready` never high.
- Contention round-robin: m0 and m1 request continuously, slave ready in 1 cycle → grants alternate 01,10,01,10; first grant m0 after reset.
- FIXED_PRIO=1, both requesting continuously → m1 never granted; drop m0 → m1 granted after next DONE+IDLE.
- Watchdog: TIMEOUT=4, m1_write, slave never ready → after 4 BUSY cycles `m1_ready`=`m1_err`=1, `s_write` low next cycle, `timeoutFlag`=1 until `clearTimeout` pulse.
- Abort: m0_read withdrawn in 2nd BUSY cycle → IDLE next cycle, no `m0_ready`, pending m1 granted in the following arbitration.
- Async reset during BUSY1 with `s_write`=1 → `s_write`, `grant` drop to 0 without clock edge; first post-reset contention grants m0.

Source files
------------

// File: rtl/data_bus_arbiter_if.sv
// One master-to-slave memory bus link: request strobes and fields one way, data/ready/err back.
// The arbiter takes two links as a slave and drives one link as a master.
interface data_bus_arbiter_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] dataOut;
  logic [1:0]  memType;
  logic [31:0] dataIn;
  logic        ready;
  logic        err;

  modport master (output read, write, addr, dataOut, memType, input dataIn, ready);
  modport slave  (input read, write, addr, dataOut, memType, output dataIn, ready, err);
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the shared memory data bus, with round-robin or fixed priority
// and a watchdog that aborts transactions the slave never completes.
module data_bus_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              res,
  data_bus_arbiter_if.slave  m0,
  data_bus_arbiter_if.slave  m1,
  data_bus_arbiter_if.master s,
  output logic [1:0]        grant,
  output logic              timeoutFlag,
  input  logic              clearTimeout
);
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, DONE} stateT;

  stateT         state;
  stateT         nextState;
  logic          lastGrant;
  logic          winner;
  logic [CW-1:0] wdCount;
  logic          req0;
  logic          req1;
  logic          busy;
  logic          owner;
  logic          curRead;
  logic          curWrite;
  logic          respReady;
  logic          respErr;

  assign req0     = m0.read | m0.write;
  assign req1     = m1.read | m1.write;
  assign busy     = (state == BUSY0) || (state == BUSY1);
  assign owner    = (state == BUSY1);
  assign curRead  = owner ? m1.read  : m0.read;
  assign curWrite = owner ? m1.write : m0.write;

  // A lone requester wins; on contention the master that did not win last time goes next.
  always_comb begin
    if (req0 && req1) winner = (FIXED_PRIO != 0) ? 1'b0 : ~lastGrant;
    else              winner = ~req0;
  end

  always_comb begin
    nextState = state;
    respReady = 1'b0;
    respErr   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) nextState = winner ? BUSY1 : BUSY0;
      end
      BUSY0, BUSY1: begin
        if (!(curRead || curWrite)) begin
          nextState = IDLE;
        end else if (s.ready) begin
          respReady = 1'b1;
          nextState = DONE;
        end else if (TIMEOUT != 0 && wdCount == CW'(LIMIT)) begin
          respReady = 1'b1;
          respErr   = 1'b1;
          nextState = DONE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state       <= IDLE;
      lastGrant   <= 1'b1;
      wdCount     <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE) begin
        wdCount <= '0;
        if (req0 || req1) lastGrant <= winner;
      end else if (busy && !s.ready && TIMEOUT != 0) begin
        wdCount <= wdCount + CW'(1);
      end
      if (respErr)           timeoutFlag <= 1'b1;
      else if (clearTimeout) timeoutFlag <= 1'b0;
    end
  end

  // Slave side sees only the owner's request; everything is quiet outside BUSY.
  assign grant     = {state == BUSY1, state == BUSY0};
  assign s.write   = busy & curWrite;
  assign s.read    = busy & curRead & ~curWrite;
  assign s.addr    = busy ? (owner ? m1.addr    : m0.addr)    : '0;
  assign s.dataOut = busy ? (owner ? m1.dataOut : m0.dataOut) : '0;
  assign s.memType = busy ? (owner ? m1.memType : m0.memType) : '0;

  assign m0.ready  = respReady & ~owner;
  assign m0.err    = respErr & ~owner;
  assign m0.dataIn = (respReady && !respErr && !owner) ? s.dataIn : '0;
  assign m1.ready  = respReady & owner;
  assign m1.err    = respErr & owner;
  assign m1.dataIn = (respReady && !respErr && owner) ? s.dataIn : '0;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: a round-robin instance with a short watchdog and a
// fixed-priority instance with the watchdog disabled, driven by the same stimulus.
module tb_data_bus_arbiter;
  localparam int TO_A = 4;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        useB = 1'b0;
  logic        m0Rd, m0Wr, m1Rd, m1Wr;
  logic [31:0] m0Addr, m0Dout, m1Addr, m1Dout;
  logic [1:0]  m0Mt, m1Mt;
  logic        sRdy;
  logic [31:0] sDin;
  logic        clr;
  int          checks = 0;
  int          errors = 0;
  bit          flagModel = 1'b0;
  bit          lastWin = 1'b1;
  bit          randClr = 1'b0;

  data_bus_arbiter_if aM0(), aM1(), aS(), bM0(), bM1(), bS();
  logic [1:0] grantA, grantB;
  logic       flagA, flagB;

  data_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT(TO_A)) dutA (
    .clk(clk), .res(res), .m0(aM0), .m1(aM1), .s(aS),
    .grant(grantA), .timeoutFlag(flagA), .clearTimeout(clr));
  data_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT(0)) dutB (
    .clk(clk), .res(res), .m0(bM0), .m1(bM1), .s(bS),
    .grant(grantB), .timeoutFlag(flagB), .clearTimeout(clr));

  assign aM0.read = m0Rd;      assign bM0.read = m0Rd;
  assign aM0.write = m0Wr;     assign bM0.write = m0Wr;
  assign aM0.addr = m0Addr;    assign bM0.addr = m0Addr;
  assign aM0.dataOut = m0Dout; assign bM0.dataOut = m0Dout;
  assign aM0.memType = m0Mt;   assign bM0.memType = m0Mt;
  assign aM1.read = m1Rd;      assign bM1.read = m1Rd;
  assign aM1.write = m1Wr;     assign bM1.write = m1Wr;
  assign aM1.addr = m1Addr;    assign bM1.addr = m1Addr;
  assign aM1.dataOut = m1Dout; assign bM1.dataOut = m1Dout;
  assign aM1.memType = m1Mt;   assign bM1.memType = m1Mt;
  assign aS.ready = sRdy;      assign bS.ready = sRdy;
  assign aS.dataIn = sDin;     assign bS.dataIn = sDin;
  assign aS.err = 1'b0;        assign bS.err = 1'b0;

  logic [1:0]  oGrant, oSMt;
  logic        oSRd, oSWr, oFlag, oRdy0, oErr0, oRdy1, oErr1;
  logic [31:0] oSAddr, oSDout, oDin0, oDin1;

  always_comb begin
    if (useB) begin
      oGrant = grantB; oFlag = flagB;
      oSRd = bS.read; oSWr = bS.write; oSAddr = bS.addr; oSDout = bS.dataOut; oSMt = bS.memType;
      oRdy0 = bM0.ready; oErr0 = bM0.err; oDin0 = bM0.dataIn;
      oRdy1 = bM1.ready; oErr1 = bM1.err; oDin1 = bM1.dataIn;
    end else begin
      oGrant = grantA; oFlag = flagA;
      oSRd = aS.read; oSWr = aS.write; oSAddr = aS.addr; oSDout = aS.dataOut; oSMt = aS.memType;
      oRdy0 = aM0.ready; oErr0 = aM0.err; oDin0 = aM0.dataIn;
      oRdy1 = aM1.ready; oErr1 = aM1.err; oDin1 = aM1.dataIn;
    end
  end

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL globalTimeout simulation did not reach the end");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] m0S;      // {write, read}
    logic [1:0] m1S;
    int         lat;      // BUSY cycle index at which the slave answers
    logic [1:0] expGrant;
    int         doneIdx;  // BUSY cycle index at which ready is expected
    bit         expErr;
  } vecT;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input bit errNow);
    if (errNow) flagModel = 1'b1;
    else if (clr) flagModel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr = randClr ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic setStrb(input logic [1:0] a, input logic [1:0] b);
    {m0Wr, m0Rd} = a;
    {m1Wr, m1Rd} = b;
    m0Addr = $urandom; m0Dout = $urandom; m0Mt = 2'($urandom_range(0, 3));
    m1Addr = $urandom; m1Dout = $urandom; m1Mt = 2'($urandom_range(0, 3));
  endtask

  task automatic doReset();
    res = 1'b1; clr = 1'b0; sRdy = 1'b0; sDin = '0;
    setStrb(2'b00, 2'b00);
    #1;
    chk("rstGrant", 32'(oGrant), 32'd0);
    chk("rstSRead", 32'(oSRd), 32'd0);
    chk("rstSWrite", 32'(oSWr), 32'd0);
    chk("rstFlag", 32'(oFlag), 32'd0);
    chk("rstReady", 32'({oRdy0, oRdy1}), 32'd0);
    @(negedge clk);
    res = 1'b0;
    flagModel = 1'b0;
    lastWin = 1'b1;
  endtask

  // Entered at a negedge in IDLE with requests applied; returns at a negedge in IDLE.
  task automatic runTxn(input logic [1:0] expGrant, input int lat, input int doneIdx,
                        input bit expErr, input bit dropAll, input bit dropWin,
                        input logic [31:0] rdata);
    bit w1, last, expRd, expWr;
    #1;
    chk("idleGrant", 32'(oGrant), 32'd0);
    cycle(1'b0);
    w1 = expGrant[1];
    for (int i = 0; i <= doneIdx; i++) begin
      sRdy = (i == lat);
      sDin = rdata;
      #1;
      last  = (i == doneIdx);
      expWr = w1 ? m1Wr : m0Wr;
      expRd = (w1 ? m1Rd : m0Rd) & ~expWr;
      chk("grant", 32'(oGrant), 32'(expGrant));
      chk("s_read", 32'(oSRd), 32'(expRd));
      chk("s_write", 32'(oSWr), 32'(expWr));
      chk("s_addr", oSAddr, w1 ? m1Addr : m0Addr);
      chk("s_dataOut", oSDout, w1 ? m1Dout : m0Dout);
      chk("s_memType", 32'(oSMt), 32'(w1 ? m1Mt : m0Mt));
      chk("m0_ready", 32'(oRdy0), 32'(last & !w1));
      chk("m1_ready", 32'(oRdy1), 32'(last & w1));
      chk("m0_err", 32'(oErr0), 32'(last & expErr & !w1));
      chk("m1_err", 32'(oErr1), 32'(last & expErr & w1));
      chk("m0_dataIn", oDin0, (last && !expErr && !w1) ? rdata : 32'd0);
      chk("m1_dataIn", oDin1, (last && !expErr && w1) ? rdata : 32'd0);
      chk("timeoutFlag", 32'(oFlag), 32'(flagModel));
      cycle(last & expErr);
    end
    sRdy = 1'b0;
    #1;
    chk("doneGrant", 32'(oGrant), 32'd0);
    chk("doneStrobes", 32'({oSRd, oSWr}), 32'd0);
    chk("doneReady", 32'({oRdy0, oRdy1}), 32'd0);
    chk("doneFlag", 32'(oFlag), 32'(flagModel));
    if (dropAll) setStrb(2'b00, 2'b00);
    else if (dropWin && w1) {m1Wr, m1Rd} = 2'b00;
    else if (dropWin) {m0Wr, m0Rd} = 2'b00;
    cycle(1'b0);
    $display("txn grant=%b lat=%0d done=%0d err=%0b", expGrant, lat, doneIdx, expErr);
  endtask

  initial begin
    vecT tbl[8];
    logic [1:0] a, b;
    bit win, err;
    int lat, done;

    tbl[0] = '{2'b01, 2'b00, 2, 2'b01, 2, 1'b0};
    tbl[1] = '{2'b00, 2'b10, 0, 2'b10, 0, 1'b0};
    tbl[2] = '{2'b01, 2'b01, 1, 2'b01, 1, 1'b0};
    tbl[3] = '{2'b01, 2'b01, 0, 2'b10, 0, 1'b0};
    tbl[4] = '{2'b11, 2'b00, 0, 2'b01, 0, 1'b0};
    tbl[5] = '{2'b00, 2'b10, 7, 2'b10, 3, 1'b1};
    tbl[6] = '{2'b01, 2'b00, 3, 2'b01, 3, 1'b0};
    tbl[7] = '{2'b01, 2'b10, 4, 2'b10, 3, 1'b1};

    doReset();
    for (int i = 0; i < 8; i++) begin
      setStrb(tbl[i].m0S, tbl[i].m1S);
      if (i == 0) m0Addr = 32'h100;
      runTxn(tbl[i].expGrant, tbl[i].lat, tbl[i].doneIdx, tbl[i].expErr, 1'b1, 1'b0, 32'hDEADBEEF);
    end
    clr = 1'b1;
    cycle(1'b0);
    #1 chk("flagCleared", 32'(oFlag), 32'd0);

    // Continuous contention alternates, m0 first after reset.
    doReset();
    setStrb(2'b01, 2'b01);
    for (int i = 0; i < 4; i++)
      runTxn((i % 2 != 0) ? 2'b10 : 2'b01, 0, 0, 1'b0, i == 3, 1'b0, $urandom);

    // m0 withdraws in its second BUSY cycle; pending m1 then gets the bus.
    setStrb(2'b01, 2'b00);
    cycle(1'b0);
    {m1Wr, m1Rd} = 2'b10;
    #1 chk("abortGrant0", 32'(oGrant), 32'b01);
    cycle(1'b0);
    {m0Wr, m0Rd} = 2'b00;
    #1;
    chk("abortReady", 32'(oRdy0), 32'd0);
    chk("abortSRead", 32'(oSRd), 32'd0);
    cycle(1'b0);
    #1;
    chk("abortIdleGrant", 32'(oGrant), 32'd0);
    chk("abortIdleReady", 32'(oRdy0), 32'd0);
    runTxn(2'b10, 0, 0, 1'b0, 1'b1, 1'b0, $urandom);

    // Asynchronous reset while m1 is writing.
    doReset();
    setStrb(2'b00, 2'b10);
    cycle(1'b0);
    #1;
    chk("preRstSWrite", 32'(oSWr), 32'd1);
    chk("preRstGrant", 32'(oGrant), 32'b10);
    #1 res = 1'b1;
    #1;
    chk("asyncSWrite", 32'(oSWr), 32'd0);
    chk("asyncGrant", 32'(oGrant), 32'd0);
    chk("asyncReady", 32'(oRdy1), 32'd0);
    @(negedge clk);
    setStrb(2'b01, 2'b01);
    res = 1'b0;
    flagModel = 1'b0;
    lastWin = 1'b1;
    runTxn(2'b01, 1, 1, 1'b0, 1'b1, 1'b0, $urandom);

    // Fixed-priority instance: m1 only after m0 lets go; no watchdog.
    useB = 1'b1;
    doReset();
    setStrb(2'b01, 2'b01);
    for (int i = 0; i < 4; i++)
      runTxn(2'b01, 0, 0, 1'b0, 1'b0, i == 3, $urandom);
    runTxn(2'b10, 0, 0, 1'b0, 1'b1, 1'b0, $urandom);
    setStrb(2'b00, 2'b10);
    runTxn(2'b10, 6, 6, 1'b0, 1'b1, 1'b0, $urandom);
    useB = 1'b0;

    // Random transactions against the arbitration and watchdog rules.
    randClr = 1'b1;
    doReset();
    for (int t = 0; t < 120; t++) begin
      do begin
        a = 2'($urandom_range(0, 3));
        b = 2'($urandom_range(0, 3));
      end while (a == 2'b00 && b == 2'b00);
      setStrb(a, b);
      if (a != 2'b00 && b != 2'b00) win = ~lastWin;
      else win = (b != 2'b00);
      lastWin = win;
      lat  = $urandom_range(0, 6);
      err  = (lat >= TO_A);
      done = err ? TO_A - 1 : lat;
      runTxn(win ? 2'b10 : 2'b01, lat, done, err, 1'b1, 1'b0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
